// File: rtl/result_drain_pkg.sv
// Shared accelerator definitions for the result drain: FSM states and the
// row-count normalisation used when a drain is started.
package result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } drain_state_t;

  // A num_rows value of zero requests every row of the array.
  localparam int unsigned ROWS_ALL = 0;

  function automatic int unsigned effective_rows(input int unsigned num_rows,
                                                 input int unsigned array_size);
    return (num_rows == ROWS_ALL || num_rows > array_size) ? array_size : num_rows;
  endfunction

endpackage

// File: rtl/result_drain.sv
// Streams result rows out of the systolic array, one row per accepted beat,
// through a single output register with valid/ready backpressure.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [ADDR_WIDTH:0]                        num_rows,
  input  logic                                       gelu_req,
  output logic [ADDR_WIDTH-1:0]                      rd_row_addr,
  output logic                                       gelu_en,
  input  logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] rd_data,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic signed [ARRAY_SIZE-1:0][ACC_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0]                      m_row,
  output logic                                       m_last,
  output logic                                       busy,
  output logic                                       drain_done,
  output drain_state_t                               dbg_state
);

  // Stream handshake: a beat transfers on any rising edge where m_valid and
  // m_ready are both high; once m_valid rises, m_data/m_row/m_last hold until
  // that transfer, and m_ready is ignored while m_valid is low.

  drain_state_t          state;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  gelu_q;
  logic                  load;
  logic                  accept;

  assign load        = (state == DRAIN) && (!m_valid || m_ready);
  assign accept      = m_valid && m_ready;
  assign rd_row_addr = row_cnt;
  assign gelu_en     = gelu_q;
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      last_idx   <= '0;
      gelu_q     <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_row      <= '0;
      m_last     <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DRAIN;
            row_cnt  <= '0;
            last_idx <= ADDR_WIDTH'(effective_rows(32'(num_rows), ARRAY_SIZE) - 1);
            gelu_q   <= gelu_req;
          end
        end
        DRAIN: begin
          if (load) begin
            // rd_data is combinational on row_cnt, so the row lands with no extra latency.
            m_data  <= rd_data;
            m_row   <= row_cnt;
            m_valid <= 1'b1;
            m_last  <= (row_cnt == last_idx);
            if (row_cnt == last_idx) begin
              state <= LAST;
            end else begin
              row_cnt <= row_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        LAST: begin
          if (accept) begin
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            drain_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain at N=4: a vector table of drains with
// varied row counts and ready patterns, plus reset and restart sequences.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = N * AW;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [2:0]                  num_rows;
  logic                        gelu_req;
  logic [1:0]                  rd_row_addr;
  logic                        gelu_en;
  logic signed [N-1:0][AW-1:0] rd_data;
  logic                        m_valid;
  logic                        m_ready;
  logic signed [N-1:0][AW-1:0] m_data;
  logic [1:0]                  m_row;
  logic                        m_last;
  logic                        busy;
  logic                        drain_done;
  drain_state_t                dbg_state;

  int data_base;
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [2:0]  nr;
    logic        g;
    logic [7:0]  rmask;
    logic [31:0] restart_mask;
    bit          flip;
    int          base;
    int          exp_r;
  } vec_t;

  vec_t vecs[9];

  result_drain #(.ARRAY_SIZE(N), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .gelu_req(gelu_req),
    .rd_row_addr(rd_row_addr), .gelu_en(gelu_en), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .busy(busy), .drain_done(drain_done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result array model: element e of row r holds base + r*10 + e.
  always_comb begin
    for (int e = 0; e < N; e++) rd_data[e] = AW'(data_base + int'(rd_row_addr) * 10 + e);
  end

  function automatic logic [DW-1:0] row_word(input int r);
    logic [DW-1:0] w;
    for (int e = 0; e < N; e++) w[e*AW +: AW] = AW'(data_base + r * 10 + e);
    return w;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_drain(input vec_t v);
    int got, done_cnt, done_cyc, last_acc, first_v, max_addr;
    int gbad, sbad, bbad, ibad;
    logic prev_stall;
    logic [DW-1:0] held_d, exp_d;
    logic [1:0] held_r;
    logic held_l;
    data_base = v.base;
    exp_q.delete();
    for (int r = 0; r < v.exp_r; r++) exp_q.push_back(row_word(r));
    got = 0; done_cnt = 0; done_cyc = -1; last_acc = -100; first_v = -1; max_addr = 0;
    gbad = 0; sbad = 0; bbad = 0; ibad = 0; prev_stall = 1'b0;
    held_d = '0; held_r = '0; held_l = 1'b0;
    @(negedge clk);
    start = 1'b1; num_rows = v.nr; gelu_req = v.g; m_ready = v.rmask[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start    = (cyc < 32) ? v.restart_mask[cyc] : 1'b0;
      num_rows = start ? 3'd1 : v.nr;
      gelu_req = (start || (v.flip && cyc >= 2)) ? ~v.g : v.g;
      if (drain_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy !== 1'b0 || m_valid !== 1'b0) ibad++;
      end else if (done_cyc >= 0) begin
        if (busy !== 1'b0 || m_valid !== 1'b0) ibad++;
      end else begin
        if (busy !== 1'b1) bbad++;
        if (gelu_en !== v.g) gbad++;
        if (int'(rd_row_addr) > max_addr) max_addr = int'(rd_row_addr);
      end
      if (m_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== held_d || m_row !== held_r || m_last !== held_l))
        sbad++;
      m_ready = v.rmask[cyc % 8];
      if (m_valid === 1'b1 && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_row", 1, 0);
        end else begin
          exp_d = exp_q.pop_front();
          check("row_data", m_data, exp_d);
          check("row_index", m_row, got);
          check("row_last", m_last, (got == v.exp_r - 1));
        end
        got++;
        last_acc = cyc;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      held_d = m_data; held_r = m_row; held_l = m_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0; m_ready = 1'b0;
    check("rows_delivered", got, v.exp_r);
    check("drain_done_count", done_cnt, 1);
    check("done_after_last_accept", done_cyc, last_acc + 1);
    check("first_valid_cycle", first_v, 1);
    check("gelu_en_held", gbad, 0);
    check("max_rd_row_addr", max_addr, v.exp_r - 1);
    check("stall_hold", sbad, 0);
    check("busy_profile", bbad, 0);
    check("idle_after_done", ibad, 0);
    if (v.rmask == 8'hFF) check("full_rate_done_cycle", done_cyc, v.exp_r + 1);
  endtask

  initial begin
    int done_seen;
    vec_t fresh;
    //             nr    g     rmask        restart       flip base exp_r
    vecs[0] = '{3'd0, 1'b0, 8'hFF,       32'h0,        0,   0,   4};
    vecs[1] = '{3'd2, 1'b0, 8'hFF,       32'h0,        0,   100, 2};
    vecs[2] = '{3'd3, 1'b1, 8'h99,       32'h0,        0,   200, 3};
    vecs[3] = '{3'd0, 1'b1, 8'h99,       32'h0,        1,   300, 4};
    vecs[4] = '{3'd5, 1'b0, 8'hFF,       32'h0,        0,   400, 4};
    vecs[5] = '{3'd7, 1'b1, 8'b01010110, 32'h0,        0,   50,  4};
    vecs[6] = '{3'd1, 1'b0, 8'hFF,       32'h0,        0,   600, 1};
    vecs[7] = '{3'd0, 1'b0, 8'hFF,       32'h14,       0,   900, 4};
    vecs[8] = '{3'd2, 1'b1, 8'h99,       32'h18,       0,   800, 2};

    rst = 1'b1; start = 1'b0; num_rows = '0; gelu_req = 1'b0; m_ready = 1'b0; data_base = 0;
    repeat (3) @(negedge clk);
    check("reset_state", dbg_state, IDLE);
    check("reset_m_valid", m_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_drain_done", drain_done, 0);
    check("reset_gelu_en", gelu_en, 0);
    check("reset_rd_row_addr", rd_row_addr, 0);
    check("reset_m_row", m_row, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_data", m_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_drain(vecs[i]);

    // Reset with row 2 pending under backpressure abandons the drain.
    @(negedge clk);
    start = 1'b1; num_rows = 3'd0; gelu_req = 1'b1; m_ready = 1'b1; data_base = 500;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_row", m_row, 2);
    check("pending_valid", m_valid, 1);
    check("pending_gelu_en", gelu_en, 1);
    m_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_gelu_en", gelu_en, 0);
    check("rst_rd_row_addr", rd_row_addr, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0; gelu_req = 1'b0; m_ready = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (drain_done === 1'b1) done_seen++;
    end
    check("rst_no_drain_done", done_seen, 0);
    check("rst_stays_idle", busy, 0);
    m_ready = 1'b0;

    fresh = '{3'd0, 1'b0, 8'hFF, 32'h0, 0, 700, 4};
    run_drain(fresh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 32, meaning the array dimension N (rows per result, elements per row).
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the FP32 result element width.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(ARRAY_SIZE), meaning the row address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a drain (driven by the array's done).
REQ-007 SHALL have port num_rows, input, ADDR_WIDTH+1 bits: rows to drain, sampled at start; 0 or values above ARRAY_SIZE mean ARRAY_SIZE.
REQ-008 SHALL have port gelu_req, input, 1 bit: apply GeLU for this drain, sampled at start.
REQ-009 SHALL have port rd_row_addr, output, ADDR_WIDTH bits: result row select toward the array.
REQ-010 SHALL have port gelu_en, output, 1 bit: activation select toward the array read path.
REQ-011 SHALL have port rd_data, input, ARRAY_SIZE x ACC_WIDTH signed: the combinational result row for rd_row_addr.
REQ-012 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, ARRAY_SIZE x ACC_WIDTH signed), m_row (output, ADDR_WIDTH) and m_last (output, 1), forming a downstream row stream.
REQ-013 SHALL have ports busy (output, 1), meaning a drain is active, and drain_done (output, 1), a one-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, DRAIN and LAST.
- IDLE -> DRAIN on start.
- DRAIN -> LAST when the final row is loaded into the output register.
- LAST -> IDLE when that row is accepted (m_valid && m_ready).
REQ-015 SHALL, at start, capture the effective row count R (1..ARRAY_SIZE) and gelu_req, and set the row counter to 0.
REQ-016 SHALL drive rd_row_addr from the row counter and gelu_en from the captured gelu_req, both held stable between loads.
REQ-017 SHALL define an output register load as: state is DRAIN and (!m_valid || m_ready).
REQ-018 SHALL, on a load, take m_data from rd_data with zero extra latency, set m_row to the counter and m_valid to 1, and set m_last to 1 iff the counter equals R-1.
REQ-019 SHALL increment the row counter by one on every load except the final load; the counter never wraps past R-1.
REQ-020 SHALL, when m_ready is held high, sustain one row per cycle: the first m_valid appears the cycle after start, and R rows complete in R cycles.
REQ-021 SHALL hold m_data, m_row, m_last and m_valid stable while m_valid && !m_ready.
REQ-022 SHALL clear m_valid the cycle after an accept unless a new load occurs in the same cycle.
REQ-023 SHALL pulse drain_done for exactly one cycle, in the cycle after the m_last row is accepted.
REQ-024 SHALL assert busy in DRAIN and LAST, and deassert it in IDLE.
REQ-025 SHALL ignore start while busy; no state or captured value changes.
REQ-026 SHALL, when start coincides with the final accept in LAST, finish the current drain and not begin a new one.
REQ-027 SHALL treat m_ready as don't-care while m_valid is 0.

Reset
REQ-028 SHALL, on rst, set state=IDLE, row counter=0, rd_row_addr=0, gelu_en=0, m_valid=0, m_last=0, m_row=0, m_data=all zeros, busy=0 and drain_done=0.
REQ-029 SHALL give rst priority over all other inputs; a mid-drain rst abandons the drain, drops m_valid immediately, and emits no drain_done.

Structure
REQ-030 SHALL place the drain FSM state enum and the num_rows-to-R normalisation constant in the shared accelerator package.
REQ-031 SHALL contain no sub-module; the output register and FSM are local, and result_drain is instantiated beside systolic logic, consuming rd_row_addr/rd_data/gelu_en.

Verification
REQ-032 SHALL cover: N=4, num_rows=0, m_ready=1, rows r hold value r*10 -> m_valid on cycles 1..4, m_row 0,1,2,3, m_last on row 3 only, drain_done at cycle 5.
REQ-033 SHALL cover: N=4, num_rows=2 -> rows 0,1 only, m_last on row 1, rd_row_addr never exceeds 1.
REQ-034 SHALL cover: m_ready toggling 1,0,0,1,... -> every row delivered exactly once, in order, with data stable during stalls.
REQ-035 SHALL cover: gelu_req=1 at start, changed to 0 mid-drain -> gelu_en stays 1 for the whole drain, and is 0 after reset.
REQ-036 SHALL cover: a second start while busy, and start in the final-accept cycle -> both ignored, exactly one drain_done.
REQ-037 SHALL cover: rst asserted with row 2 pending and m_ready=0 -> next cycle m_valid=0, busy=0, no drain_done, and a fresh start drains from row 0.
